// File: rtl/div_pkg.sv
// Shared definitions for the serial BCD divider host: FSM states and link-format constants.
package div_pkg;

  localparam int unsigned XS3_OFFSET       = 3;
  localparam int unsigned NUM_DIGITS       = 4;
  localparam int unsigned RESULT_W_DEFAULT = 10;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StRecv,
    StDone
  } state_e;

endpackage

// File: rtl/divider_host.sv
// Host side of a serial divider link: sends four excess-3 digits, then collects an MSB-first
// result with timeout and framing checks, and reports it as a one-cycle response.
module divider_host
  import div_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned RESULT_W = RESULT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [15:0]         req_digits,
  output logic                tx_valid,
  output logic [3:0]          tx_data,
  input  logic                rx_valid,
  input  logic                rx_data,
  output logic                rsp_valid,
  output logic [RESULT_W-1:0] rsp_quotient,
  output logic                rsp_div0,
  output logic                rsp_err
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam int unsigned BitW  = $clog2(RESULT_W + 1);
  localparam int unsigned SendW = $clog2(NUM_DIGITS);

  state_e              state_q;
  logic [15:0]         digits_q;
  logic [SendW-1:0]    send_cnt_q;
  logic [WaitW-1:0]    wait_cnt_q;
  logic [BitW-1:0]     bit_cnt_q;
  logic [RESULT_W-1:0] shift_q;
  logic                tx_valid_q;
  logic [3:0]          tx_data_q;
  logic                rsp_valid_q;
  logic [RESULT_W-1:0] rsp_quotient_q;
  logic                rsp_div0_q;
  logic                rsp_err_q;

  logic [3:0]          next_digit;
  logic [RESULT_W-1:0] shift_next;

  // Digit to put on the link in the cycle after the one currently being sent.
  always_comb begin
    next_digit = 4'h0;
    unique case (send_cnt_q)
      2'd0:    next_digit = digits_q[11:8];
      2'd1:    next_digit = digits_q[7:4];
      2'd2:    next_digit = digits_q[3:0];
      default: next_digit = 4'h0;
    endcase
    shift_next = {shift_q[RESULT_W-2:0], rx_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      digits_q       <= '0;
      send_cnt_q     <= '0;
      wait_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= 4'h0;
      rsp_valid_q    <= 1'b0;
      rsp_quotient_q <= '0;
      rsp_div0_q     <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            digits_q   <= req_digits;
            send_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= req_digits[15:12] + 4'(XS3_OFFSET);
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (send_cnt_q == SendW'(NUM_DIGITS - 1)) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 4'h0;
            wait_cnt_q <= '0;
            state_q    <= StWait;
          end else begin
            send_cnt_q <= send_cnt_q + SendW'(1);
            tx_data_q  <= next_digit + 4'(XS3_OFFSET);
          end
        end
        StWait: begin
          if (rx_valid) begin
            shift_q   <= {{(RESULT_W - 1){1'b0}}, rx_data};
            bit_cnt_q <= BitW'(1);
            state_q   <= StRecv;
          end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
            rsp_valid_q    <= 1'b1;
            rsp_quotient_q <= '0;
            rsp_div0_q     <= 1'b0;
            rsp_err_q      <= 1'b1;
            state_q        <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StRecv: begin
          if (rx_valid) begin
            shift_q   <= shift_next;
            bit_cnt_q <= bit_cnt_q + BitW'(1);
            if (bit_cnt_q == BitW'(RESULT_W - 1)) begin
              rsp_valid_q    <= 1'b1;
              rsp_quotient_q <= shift_next;
              rsp_div0_q     <= &shift_next;
              rsp_err_q      <= 1'b0;
              state_q        <= StDone;
            end
          end else begin
            // Gap in the result stream: frame is broken, drop the partial value.
            rsp_valid_q    <= 1'b1;
            rsp_quotient_q <= '0;
            rsp_div0_q     <= 1'b0;
            rsp_err_q      <= 1'b1;
            state_q        <= StDone;
          end
        end
        StDone: begin
          rsp_div0_q <= 1'b0;
          rsp_err_q  <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_quotient = rsp_quotient_q;
  assign rsp_div0     = rsp_div0_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_divider_host.sv
// Directed bench for divider_host: digit encoding, result reception, div0, timeout,
// framing error, mid-transaction reset and held request strobe.
module tb_divider_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_digits;
  logic        tx_valid;
  logic [3:0]  tx_data;
  logic        rx_valid;
  logic        rx_data;
  logic        rsp_valid;
  logic [9:0]  rsp_quotient;
  logic        rsp_div0;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  divider_host #(
    .TIMEOUT (64),
    .RESULT_W(10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_digits  (req_digits),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rsp_valid   (rsp_valid),
    .rsp_quotient(rsp_quotient),
    .rsp_div0    (rsp_div0),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; req_digits = '0; rx_valid = 1'b0; rx_data = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Returns in the first SEND cycle.
  task automatic accept(input logic [15:0] d);
    req_digits = d;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic drive_bits(input logic [9:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = bits[9-i];
      tick();
    end
    rx_valid = 1'b0;
    rx_data  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_digits = 16'h1234; rx_valid = 1'b1; rx_data = 1'b1;
    tick();
    tick();
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 4'h0) begin
      errors++; $display("FAIL reset_tx: got valid=%b data=%0d, want 0/0", tx_valid, tx_data);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_quotient !== 10'd0 || rsp_div0 !== 1'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: got v=%b q=%0d d0=%b e=%b, want all 0",
                         rsp_valid, rsp_quotient, rsp_div0, rsp_err);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b, want 1", req_ready);
    end
    rst = 1'b0; req_valid = 1'b0; rx_valid = 1'b0; rx_data = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] exp [4];
    exp = '{4'd4, 4'd5, 4'd6, 4'd7};
    accept(16'h1234);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[i] || req_ready !== 1'b0) begin
        errors++; $display("FAIL basic_tx%0d: got v=%b d=%0d rdy=%b, want 1/%0d/0",
                           i, tx_valid, tx_data, req_ready, exp[i]);
      end
      if (i < 3) tick();
    end
    tick();
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 4'h0) begin
      errors++; $display("FAIL basic_wait_tx: got v=%b d=%0d, want 0/0", tx_valid, tx_data);
    end
    drive_bits(10'b0010001100, 10);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_quotient !== 10'd140 || rsp_err !== 1'b0 || rsp_div0 !== 1'b0) begin
      errors++; $display("FAIL basic_rsp: got v=%b q=%0d e=%b d0=%b, want 1/140/0/0",
                         rsp_valid, rsp_quotient, rsp_err, rsp_div0);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_quotient !== 10'd140) begin
      errors++; $display("FAIL basic_after: got v=%b rdy=%b q=%0d, want 0/1/140",
                         rsp_valid, req_ready, rsp_quotient);
    end
  endtask

  task automatic test_div0();
    accept(16'h0000);
    repeat (4) tick();
    drive_bits(10'h3FF, 10);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_quotient !== 10'd1023 || rsp_div0 !== 1'b1 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL div0_rsp: got v=%b q=%0d d0=%b e=%b, want 1/1023/1/0",
                         rsp_valid, rsp_quotient, rsp_div0, rsp_err);
    end
    tick();
  endtask

  task automatic test_framing();
    accept(16'h4321);
    repeat (4) tick();
    drive_bits(10'b1011100000, 5);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL framing_early: got rsp_valid=%b, want 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_quotient !== 10'd0 || rsp_div0 !== 1'b0) begin
      errors++; $display("FAIL framing_rsp: got v=%b e=%b q=%0d d0=%b, want 1/1/0/0",
                         rsp_valid, rsp_err, rsp_quotient, rsp_div0);
    end
    tick();
  endtask

  task automatic test_timeout();
    int count;
    accept(16'h9876);
    repeat (4) tick();
    count = 0;
    // rx_data toggles while rx_valid stays low; it must not matter.
    while (rsp_valid !== 1'b1 && count < 200) begin
      rx_data = ~rx_data;
      tick();
      count++;
    end
    rx_data = 1'b0;
    checks++;
    if (count !== 64) begin
      errors++; $display("FAIL timeout_latency: got %0d cycles, want 64", count);
    end
    checks++;
    if (rsp_err !== 1'b1 || rsp_quotient !== 10'd0) begin
      errors++; $display("FAIL timeout_rsp: got e=%b q=%0d, want 1/0", rsp_err, rsp_quotient);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: got rdy=%b v=%b, want 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    accept(16'h1234);
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 4'd5) begin
      errors++; $display("FAIL rstmid_pre: got v=%b d=%0d, want 1/5", tx_valid, tx_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 4'h0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort: got v=%b d=%0d rdy=%b rsp=%b, want 0/0/1/0",
                         tx_valid, tx_data, req_ready, rsp_valid);
    end
    rst = 1'b0;
    accept(16'h9999);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 4'd12 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_tx%0d: got v=%b d=%0d rsp=%b, want 1/12/0",
                           i, tx_valid, tx_data, rsp_valid);
      end
      tick();
    end
    repeat (3) begin
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_norsp: got rsp_valid=%b, want 0", rsp_valid);
      end
      tick();
    end
    drive_bits(10'h3FF, 1);
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      errors++; $display("FAIL rstmid_end: got v=%b e=%b, want 1/1", rsp_valid, rsp_err);
    end
    tick();
  endtask

  task automatic test_held_valid();
    logic [3:0] exp [4];
    exp = '{4'd8, 4'd9, 4'd10, 4'd11};
    req_digits = 16'h5678;
    req_valid  = 1'b1;
    tick();
    req_digits = 16'hDEF0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
        errors++; $display("FAIL held_tx%0d: got v=%b d=%0d, want 1/%0d", i, tx_valid, tx_data, exp[i]);
      end
      req_valid = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL held_wait: got rdy=%b v=%b, want 0/0", req_ready, tx_valid);
    end
    drive_bits(10'b0101010101, 10);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_quotient !== 10'd341 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL held_rsp: got v=%b q=%0d e=%b, want 1/341/0",
                         rsp_valid, rsp_quotient, rsp_err);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL held_idle: got rdy=%b v=%b, want 1/0", req_ready, tx_valid);
    end
    tick();
    // Second accept picks up 0xDEF0: 13,14,15 wrap modulo 16.
    req_valid = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 4'd0) begin
      errors++; $display("FAIL held_second_d0: got v=%b d=%0d, want 1/0", tx_valid, tx_data);
    end
    tick();
    checks++;
    if (tx_data !== 4'd1) begin
      errors++; $display("FAIL held_second_d1: got %0d, want 1", tx_data);
    end
    tick();
    checks++;
    if (tx_data !== 4'd2) begin
      errors++; $display("FAIL held_second_d2: got %0d, want 2", tx_data);
    end
    tick();
    checks++;
    if (tx_data !== 4'd3) begin
      errors++; $display("FAIL held_second_d3: got %0d, want 3", tx_data);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div0();
    test_framing();
    test_timeout();
    test_reset_mid();
    test_held_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divider_host.md
DIVIDER_HOST -- requirements
Module: divider_host

Interface
REQ-001 Parameter: TIMEOUT, default 64, maximum WAIT cycles before the response is abandoned.
REQ-002 Parameter: RESULT_W, default 10, number of result bits received.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request strobe; sampled only while req_ready=1.
REQ-006 req_ready  output  1  high only in IDLE.
REQ-007 req_digits  input  16  four BCD digits, [15:12] sent first, [3:0] sent last.
REQ-008 tx_valid  output  1  serial-link valid toward the divider (its in_valid).
REQ-009 tx_data  output  4  excess-3 encoded digit toward the divider (its in_data).
REQ-010 rx_valid  input  1  result valid from the divider (its out_valid).
REQ-011 rx_data  input  1  result bit from the divider (its out_data), MSB first.
REQ-012 rsp_valid  output  1  one-cycle response pulse.
REQ-013 rsp_quotient  output  RESULT_W  received quotient; held until the next response.
REQ-014 rsp_div0  output  1  high with rsp_valid when rsp_quotient is all ones (divisor-zero code, 1023).
REQ-015 rsp_err  output  1  high with rsp_valid on timeout or framing error.

Function
REQ-016 FSM states SHALL be IDLE, SEND, WAIT, RECV and DONE.
REQ-017 IDLE->SEND on req_valid=1: capture req_digits and clear the bit counter.
REQ-018 SEND SHALL last exactly 4 cycles, starting the cycle after acceptance, with tx_valid=1 and tx_data=(digit+3) mod 16, in order [15:12],[11:8],[7:4],[3:0].
REQ-019 tx_valid/tx_data SHALL be registered outputs; tx_data=0 whenever tx_valid=0.
REQ-020 SEND->WAIT after the 4th digit; the WAIT cycle counter clears on entry.
REQ-021 In WAIT, rx_valid=1 SHALL shift rx_data in as the MSB and move to RECV; otherwise the counter increments.
REQ-022 WAIT->DONE with rsp_err=1 and rsp_quotient=0 when the counter reaches TIMEOUT with no rx_valid.
REQ-023 In RECV, each cycle with rx_valid=1 SHALL shift in one bit; after RESULT_W total bits -> DONE with rsp_err=0.
REQ-024 In RECV, rx_valid=0 before RESULT_W bits SHALL go to DONE with rsp_err=1 and rsp_quotient=0 (framing error).
REQ-025 In DONE, rsp_valid=1 for exactly one cycle, then return to IDLE; back-to-back requests are therefore separated by at least one IDLE cycle.
REQ-026 rx_valid/rx_data SHALL be ignored in IDLE, SEND and DONE.
REQ-027 req_valid SHALL be ignored outside IDLE; captured digits do not change mid-transaction.
REQ-028 Digits >9 SHALL NOT be checked; they are encoded modulo 16.
REQ-029 Worst-case latency from acceptance to rsp_valid = 4 + TIMEOUT + RESULT_W + 1 cycles.

Reset
REQ-030 While rst=1: state=IDLE, all counters=0, tx_valid=0, tx_data=0, rsp_valid=0, rsp_quotient=0, rsp_div0=0, rsp_err=0.
REQ-031 Reset asserted mid-transaction SHALL abort it immediately, with no rsp_valid; the first accept is possible the cycle after rst deasserts.

Structure
REQ-032 The shared package div_pkg SHALL hold the FSM state enum, XS3_OFFSET=3, NUM_DIGITS=4 and the RESULT_W default.
REQ-033 The block SHALL be a single module with no sub-module; the encoder is inline arithmetic.

Verification
REQ-034 digits 1,2,3,4 -> tx_data 4,5,6,7 on 4 consecutive cycles; then drive bits 0010001100 -> rsp_quotient=140, rsp_err=0, rsp_div0=0.
REQ-035 Drive ten 1-bits in RECV -> rsp_quotient=1023, rsp_div0=1, rsp_err=0.
REQ-036 No rx_valid after SEND, TIMEOUT=64 -> rsp_valid 64 cycles after WAIT entry, rsp_err=1, rsp_quotient=0.
REQ-037 rx_valid drops after 5 bits -> rsp_valid next cycle, rsp_err=1, rsp_quotient=0.
REQ-038 rst pulse during the 2nd SEND cycle -> tx_valid=0 immediately, no rsp_valid; a new request of 9,9,9,9 then sends 12,12,12,12.
REQ-039 req_valid held high through a transaction -> exactly one transaction per IDLE visit; pulses during SEND/WAIT are ignored.
